selectio_align_ctrl: RTL and testbench
======================================

Name: selectio_align_ctrl

Overview:
- Sequences bring-up of the ADC SelectIO capture path in the clk_stream domain.
- Order of operations:
  - Hold the SelectIO clock and IO resets in a fixed order.
  - Wait for IDELAYCTRL ready.
  - Bitslip the deserialiser until the ADC frame/training pattern matches.
- Reports lock or error to control logic.
- Retries the whole sequence a bounded number of times.

Parameters:
- DW, 8: deserialised frame word width.
- TRAIN_PATTERN, 8'hF0: expected frame word when aligned.
- CLK_RST_CYCLES, 16: cycles sel_clk_rst is held.
- IO_RST_CYCLES, 16: cycles sel_io_rst is held after sel_clk_rst releases.
- RDY_TIMEOUT, 1024: max cycles to wait for idelay_rdy.
- SLIP_WAIT, 4: settle cycles after each bitslip pulse.
- MATCH_COUNT, 16: consecutive matching valid words required for lock.
- MAX_RETRY, 3: full-sequence retries before error.

Ports:
- clk_stream  in  1  stream clock; the only clock.
- rst_stream  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; restarts the sequence from the beginning.
- idelay_rdy  in  1  IDELAYCTRL ready, already synchronised to clk_stream.
- frame_valid  in  1  frame_data qualifier.
- frame_data  in  DW  deserialised frame word, in the clk_stream domain.
- sel_clk_rst  out  1  SelectIO clock-path reset.
- sel_io_rst  out  1  SelectIO ISERDES/IO reset.
- bitslip  out  1  one-cycle bitslip pulse.
- locked  out  1  alignment achieved.
- error  out  1  retries exhausted.
- slip_cnt  out  clog2(DW+1)  bitslips issued in the current attempt.
- retry_cnt  out  2  retries consumed.
- state  out  3  encoded FSM state, for debug.

Behaviour:
- FSM states and encodings:
  - RST_CLK=0, RST_IO=1, WAIT_RDY=2, CHECK=3, SLIP=4, SETTLE=5, LOCKED=6, ERROR=7.
- Reset (rst_stream=1 at a clock edge):
  - state=RST_CLK.
  - sel_clk_rst=1, sel_io_rst=1.
  - bitslip=0, locked=0, error=0.
  - slip_cnt=0, retry_cnt=0, all internal counters 0.
  - The sequence starts automatically once reset is released.
- Priority order: rst_stream > start > normal transitions.
- start in any state: next cycle behaves exactly as reset.
- RST_CLK:
  - Both resets high for exactly CLK_RST_CYCLES cycles, counted from entry.
  - Then RST_IO.
- RST_IO:
  - sel_clk_rst=0, sel_io_rst=1 for exactly IO_RST_CYCLES cycles.
  - Then WAIT_RDY.
- WAIT_RDY:
  - Both resets low.
  - idelay_rdy=1 sampled → CHECK next cycle, with match counter=0.
  - RDY_TIMEOUT cycles without ready → RETRY decision.
- CHECK: acts only on frame_valid=1.
  - Match (frame_data==TRAIN_PATTERN): match counter+1; at MATCH_COUNT → LOCKED.
  - Mismatch: match counter=0.
    - slip_cnt<DW → SLIP.
    - slip_cnt==DW → RETRY decision.
- SLIP:
  - bitslip=1 for exactly this one cycle.
  - slip_cnt+1.
  - → SETTLE.
- SETTLE:
  - frame_valid ignored for SLIP_WAIT cycles.
  - → CHECK with match counter=0.
- LOCKED:
  - locked=1, registered, asserted the cycle after entry.
  - Valid mismatch → locked=0 next cycle, slip_cnt=0, → SLIP. Resets are not re-asserted.
  - Invalid cycles are ignored.
- RETRY decision (combinational branch, not a state):
  - retry_cnt<MAX_RETRY → retry_cnt+1, slip_cnt=0, → RST_CLK.
  - Otherwise → ERROR.
- ERROR:
  - error=1, locked=0, both resets low.
  - Held until start or rst_stream.
- Output registration:
  - All outputs are registered.
  - sel_clk_rst and sel_io_rst are glitch-free.
  - sel_io_rst is never low while sel_clk_rst is high.
- Counter widths:
  - Sized for their maximum value; no wrap in any reachable path.
  - RDY_TIMEOUT counter saturates.
- Simultaneous events:
  - Match reaching MATCH_COUNT on the same cycle as start → start wins; locked stays 0.
  - frame_valid during SLIP or SETTLE → ignored.

Test Plan:
- Release reset; idelay_rdy high at cycle 40; constant 8'hF0 stream, valid every cycle:
  - sel_clk_rst high cycles 0–15.
  - sel_io_rst high cycles 0–31.
  - No bitslip.
  - locked=1 exactly 17 cycles after entering CHECK.
  - slip_cnt=0.
- Data pattern rotated by 3 bits, model rotates back one bit per bitslip pulse:
  - Exactly 3 one-cycle bitslip pulses, each separated by ≥SLIP_WAIT+1 cycles.
  - slip_cnt=3, then locked=1.
- idelay_rdy held low:
  - 4 full reset sequences (retry_cnt 1, 2, 3).
  - Then error=1, state=7, both resets low.
  - start → error=0, sequence restarts, retry_cnt=0.
- Never-matching pattern 8'h00 with idelay_rdy=1:
  - 8 bitslips per attempt; retry on the 9th mismatch.
  - After 4 attempts: error=1.
- Locked, then one valid mismatch word injected:
  - locked falls next cycle, bitslip pulses, slip_cnt counts from 1.
  - Relocks after 16 matches.
- start asserted mid-SETTLE, and separately rst_stream asserted together with start:
  - Both cases: next cycle state=RST_CLK, sel_clk_rst=1, sel_io_rst=1, counters 0.

Source files
------------

// File: rtl/selectio_align_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : selectio_align_ctrl
// Brief    : Bring-up sequencer for the ADC SelectIO capture path: ordered
//            clock/IO resets, IDELAYCTRL ready wait, bitslip-to-training lock.
// Revision : 1.0 - initial release
// ============================================================================
module selectio_align_ctrl #(
    parameter int              DW             = 8,
    parameter logic [DW-1:0]   TRAIN_PATTERN  = 8'hF0,
    parameter int              CLK_RST_CYCLES = 16,
    parameter int              IO_RST_CYCLES  = 16,
    parameter int              RDY_TIMEOUT    = 1024,
    parameter int              SLIP_WAIT      = 4,
    parameter int              MATCH_COUNT    = 16,
    parameter int              MAX_RETRY      = 3
) (
    input  logic                       clk_stream,
    input  logic                       rst_stream,
    input  logic                       start,
    input  logic                       idelay_rdy,
    input  logic                       frame_valid,
    input  logic [DW-1:0]              frame_data,
    output logic                       sel_clk_rst,
    output logic                       sel_io_rst,
    output logic                       bitslip,
    output logic                       locked,
    output logic                       error,
    output logic [$clog2(DW+1)-1:0]    slip_cnt,
    output logic [1:0]                 retry_cnt,
    output logic [2:0]                 state
);

    localparam int c_SW     = $clog2(DW + 1);
    localparam int c_MW     = $clog2(MATCH_COUNT + 1);
    localparam int c_MAX_AB = (CLK_RST_CYCLES > IO_RST_CYCLES) ? CLK_RST_CYCLES : IO_RST_CYCLES;
    localparam int c_MAX_CD = (RDY_TIMEOUT > SLIP_WAIT) ? RDY_TIMEOUT : SLIP_WAIT;
    localparam int c_MAX_PH = (c_MAX_AB > c_MAX_CD) ? c_MAX_AB : c_MAX_CD;
    localparam int c_CW     = $clog2(c_MAX_PH + 1);

    localparam logic [c_CW-1:0] c_CLK_LAST    = c_CW'(CLK_RST_CYCLES - 1);
    localparam logic [c_CW-1:0] c_IO_LAST     = c_CW'(IO_RST_CYCLES - 1);
    localparam logic [c_CW-1:0] c_RDY_LAST    = c_CW'(RDY_TIMEOUT - 1);
    localparam logic [c_CW-1:0] c_SETTLE_LAST = c_CW'(SLIP_WAIT - 1);
    localparam logic [c_MW-1:0] c_MATCH_LAST  = c_MW'(MATCH_COUNT - 1);
    localparam logic [c_MW-1:0] c_MATCH_FULL  = c_MW'(MATCH_COUNT);
    localparam logic [c_SW-1:0] c_SLIP_MAX    = c_SW'(DW);
    localparam logic [1:0]      c_RETRY_MAX   = 2'(MAX_RETRY);

    localparam logic [2:0] c_S_RST_CLK  = 3'd0;
    localparam logic [2:0] c_S_RST_IO   = 3'd1;
    localparam logic [2:0] c_S_WAIT_RDY = 3'd2;
    localparam logic [2:0] c_S_CHECK    = 3'd3;
    localparam logic [2:0] c_S_SLIP     = 3'd4;
    localparam logic [2:0] c_S_SETTLE   = 3'd5;
    localparam logic [2:0] c_S_LOCKED   = 3'd6;
    localparam logic [2:0] c_S_ERROR    = 3'd7;

    logic [2:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [c_MW-1:0] r_match_cnt;
    logic [c_SW-1:0] r_slip_cnt;
    logic [1:0]      r_retry_cnt;
    logic            r_sel_clk_rst;
    logic            r_sel_io_rst;
    logic            r_bitslip;
    logic            r_locked;
    logic            r_error;

    logic [2:0]      w_state_next;
    logic [c_CW-1:0] w_cnt_next;
    logic [c_MW-1:0] w_match_next;
    logic [c_SW-1:0] w_slip_next;
    logic [1:0]      w_retry_next;
    logic            w_retry;
    logic            w_match;

    assign w_match = (frame_data == TRAIN_PATTERN);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_match_next = r_match_cnt;
        w_slip_next  = r_slip_cnt;
        w_retry_next = r_retry_cnt;
        w_retry      = 1'b0;
        case (r_state)
            c_S_RST_CLK: begin
                if (r_cnt == c_CLK_LAST) begin
                    w_state_next = c_S_RST_IO;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            c_S_RST_IO: begin
                if (r_cnt == c_IO_LAST) begin
                    w_state_next = c_S_WAIT_RDY;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            c_S_WAIT_RDY: begin
                if (idelay_rdy) begin
                    w_state_next = c_S_CHECK;
                    w_cnt_next   = '0;
                    w_match_next = '0;
                end else if (r_cnt >= c_RDY_LAST) begin
                    w_retry = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            c_S_CHECK: begin
                if (frame_valid) begin
                    if (w_match) begin
                        if (r_match_cnt >= c_MATCH_LAST) begin
                            w_state_next = c_S_LOCKED;
                            w_match_next = c_MATCH_FULL;
                        end else begin
                            w_match_next = r_match_cnt + 1'b1;
                        end
                    end else begin
                        w_match_next = '0;
                        if (r_slip_cnt < c_SLIP_MAX) begin
                            w_state_next = c_S_SLIP;
                        end else begin
                            w_retry = 1'b1;
                        end
                    end
                end
            end
            c_S_SLIP: begin
                w_slip_next  = r_slip_cnt + 1'b1;
                w_state_next = c_S_SETTLE;
                w_cnt_next   = '0;
            end
            c_S_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_state_next = c_S_CHECK;
                    w_cnt_next   = '0;
                    w_match_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            c_S_LOCKED: begin
                // Loss of alignment re-slips from zero without redoing the resets
                if (frame_valid && !w_match) begin
                    w_state_next = c_S_SLIP;
                    w_slip_next  = '0;
                    w_match_next = '0;
                end
            end
            c_S_ERROR: begin
                w_state_next = c_S_ERROR;
            end
            default: begin
                w_state_next = c_S_RST_CLK;
                w_cnt_next   = '0;
            end
        endcase

        if (w_retry) begin
            w_cnt_next   = '0;
            w_match_next = '0;
            if (r_retry_cnt < c_RETRY_MAX) begin
                w_retry_next = r_retry_cnt + 1'b1;
                w_slip_next  = '0;
                w_state_next = c_S_RST_CLK;
            end else begin
                w_state_next = c_S_ERROR;
            end
        end
    end

    // Outputs decode the next state so they change on the same edge as r_state
    always_ff @(posedge clk_stream) begin
        if (rst_stream || start) begin
            r_state       <= c_S_RST_CLK;
            r_cnt         <= '0;
            r_match_cnt   <= '0;
            r_slip_cnt    <= '0;
            r_retry_cnt   <= '0;
            r_sel_clk_rst <= 1'b1;
            r_sel_io_rst  <= 1'b1;
            r_bitslip     <= 1'b0;
            r_locked      <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_match_cnt   <= w_match_next;
            r_slip_cnt    <= w_slip_next;
            r_retry_cnt   <= w_retry_next;
            r_sel_clk_rst <= (w_state_next == c_S_RST_CLK);
            r_sel_io_rst  <= (w_state_next == c_S_RST_CLK) || (w_state_next == c_S_RST_IO);
            r_bitslip     <= (w_state_next == c_S_SLIP);
            r_locked      <= (w_state_next == c_S_LOCKED) && (r_state == c_S_LOCKED);
            r_error       <= (w_state_next == c_S_ERROR);
        end
    end

    assign state       = r_state;
    assign sel_clk_rst = r_sel_clk_rst;
    assign sel_io_rst  = r_sel_io_rst;
    assign bitslip     = r_bitslip;
    assign locked      = r_locked;
    assign error       = r_error;
    assign slip_cnt    = r_slip_cnt;
    assign retry_cnt   = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_selectio_align_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_selectio_align_ctrl
// Brief    : Directed self-checking bench for selectio_align_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_selectio_align_ctrl;

    localparam logic [7:0] c_TRAIN = 8'hF0;

    logic       clk_stream = 1'b0;
    logic       rst_stream;
    logic       start;
    logic       idelay_rdy;
    logic       frame_valid;
    logic [7:0] frame_data;
    logic       sel_clk_rst;
    logic       sel_io_rst;
    logic       bitslip;
    logic       locked;
    logic       error;
    logic [3:0] slip_cnt;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    logic       use_const;
    logic [7:0] const_word;
    logic [2:0] rot;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int dbl = 0;
    int min_gap = 100000;
    int last_pulse = -100000;
    logic prev_bs = 1'b0;

    always #5 clk_stream = ~clk_stream;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < int'(n); i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    assign frame_data = use_const ? const_word : rotl8(c_TRAIN, rot);

    selectio_align_ctrl dut (
        .clk_stream (clk_stream),
        .rst_stream (rst_stream),
        .start      (start),
        .idelay_rdy (idelay_rdy),
        .frame_valid(frame_valid),
        .frame_data (frame_data),
        .sel_clk_rst(sel_clk_rst),
        .sel_io_rst (sel_io_rst),
        .bitslip    (bitslip),
        .locked     (locked),
        .error      (error),
        .slip_cnt   (slip_cnt),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    // Each bitslip seen at an edge rotates the modelled deserialiser back one bit
    task automatic tick();
        @(posedge clk_stream);
        if (bitslip) begin
            pulses++;
            if (prev_bs) dbl++;
            if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
            last_pulse = cyc;
            rot = rot - 3'd1;
        end
        prev_bs = bitslip;
        cyc++;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_restart(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_clkrst"}, 32'(sel_clk_rst), 1);
        chk({tag, "_iorst"}, 32'(sel_io_rst), 1);
        chk({tag, "_slip"}, 32'(slip_cnt), 0);
        chk({tag, "_retry"}, 32'(retry_cnt), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_bitslip"}, 32'(bitslip), 0);
        chk({tag, "_error"}, 32'(error), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        int exp_state;
        rst_stream  = 1'b1;
        start       = 1'b0;
        idelay_rdy  = 1'b0;
        frame_valid = 1'b1;
        use_const   = 1'b1;
        const_word  = c_TRAIN;
        rot         = 3'd0;
        ticks(3);
        rst_stream = 1'b0;

        // T1: reset state, aligned stream, ready at cycle 40
        chk_restart("rst");
        for (int c = 0; c <= 62; c++) begin
            exp_state = (c < 16) ? 0 : (c < 32) ? 1 : (c <= 40) ? 2 : (c <= 56) ? 3 : 6;
            chk("t1_state", 32'(state), 32'(exp_state));
            chk("t1_clkrst", 32'(sel_clk_rst), 32'(c <= 15));
            chk("t1_iorst", 32'(sel_io_rst), 32'(c <= 31));
            chk("t1_locked", 32'(locked), 32'(c >= 58));
            idelay_rdy = (c >= 40);
            tick();
        end
        chk("t1_pulses", 32'(pulses), 0);
        chk("t1_slip", 32'(slip_cnt), 0);

        // T2: stream rotated by 3 bits
        use_const = 1'b0;
        rot = 3'd3;
        pulse_start();
        pulses = 0;
        min_gap = 100000;
        n = 0;
        while (!locked && n < 400) begin
            tick();
            n++;
        end
        chk("t2_locked", 32'(locked), 1);
        chk("t2_pulses", 32'(pulses), 3);
        chk("t2_double", 32'(dbl), 0);
        chk("t2_gap_ok", 32'(min_gap >= 5), 1);
        chk("t2_slip", 32'(slip_cnt), 3);
        chk("t2_rot", 32'(rot), 0);
        chk("t2_state", 32'(state), 6);

        // T3: single mismatching word while locked
        use_const  = 1'b1;
        const_word = 8'h00;
        tick();
        const_word = c_TRAIN;
        chk("t3_locked_fall", 32'(locked), 0);
        chk("t3_state_slip", 32'(state), 4);
        chk("t3_bitslip", 32'(bitslip), 1);
        chk("t3_slip0", 32'(slip_cnt), 0);
        tick();
        chk("t3_state_settle", 32'(state), 5);
        chk("t3_slip1", 32'(slip_cnt), 1);
        chk("t3_bitslip_low", 32'(bitslip), 0);
        ticks(20);
        chk("t3_relock_state", 32'(state), 6);
        chk("t3_locked_lag", 32'(locked), 0);
        tick();
        chk("t3_relocked", 32'(locked), 1);
        chk("t3_slip_keep", 32'(slip_cnt), 1);
        chk("t3_retry", 32'(retry_cnt), 0);

        // T4: start during SETTLE
        const_word = 8'h00;
        tick();
        const_word = c_TRAIN;
        ticks(2);
        chk("t4_in_settle", 32'(state), 5);
        pulse_start();
        chk_restart("t4");

        // T5: rst_stream together with start, mid-sequence
        idelay_rdy = 1'b0;
        ticks(4);
        rst_stream = 1'b1;
        start = 1'b1;
        tick();
        rst_stream = 1'b0;
        start = 1'b0;
        chk_restart("t5");

        // T6: ready never arrives, four full attempts then error
        for (int a = 0; a < 4; a++) begin
            chk("t6_att_state", 32'(state), 0);
            chk("t6_att_retry", 32'(retry_cnt), 32'(a));
            chk("t6_att_clkrst", 32'(sel_clk_rst), 1);
            ticks(1055);
            chk("t6_wait_end", 32'(state), 2);
            tick();
        end
        chk("t6_error", 32'(error), 1);
        chk("t6_state", 32'(state), 7);
        chk("t6_clkrst", 32'(sel_clk_rst), 0);
        chk("t6_iorst", 32'(sel_io_rst), 0);
        chk("t6_retry", 32'(retry_cnt), 3);
        ticks(10);
        chk("t6_error_held", 32'(error), 1);
        chk("t6_state_held", 32'(state), 7);
        pulse_start();
        chk_restart("t6_start");

        // T7: never-matching data, 8 slips per attempt
        idelay_rdy = 1'b1;
        const_word = 8'h00;
        for (int a = 0; a < 4; a++) begin
            pulses = 0;
            chk("t7_att_state", 32'(state), 0);
            chk("t7_att_retry", 32'(retry_cnt), 32'(a));
            chk("t7_att_slip", 32'(slip_cnt), 0);
            ticks(81);
            chk("t7_last_check", 32'(state), 3);
            chk("t7_slip8", 32'(slip_cnt), 8);
            chk("t7_pulses", 32'(pulses), 8);
            tick();
        end
        chk("t7_error", 32'(error), 1);
        chk("t7_state", 32'(state), 7);
        chk("t7_locked", 32'(locked), 0);

        // T8: start on the cycle the 16th match arrives
        const_word = c_TRAIN;
        pulse_start();
        ticks(48);
        chk("t8_in_check", 32'(state), 3);
        pulse_start();
        chk("t8_state", 32'(state), 0);
        chk("t8_locked", 32'(locked), 0);
        tick();
        chk("t8_locked_after", 32'(locked), 0);
        chk("t8_clkrst", 32'(sel_clk_rst), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
